resp_analyzer: RTL and testbench



---
 rtl/resp_analyzer.sv | 119 +++++++++++
 tb/tb_resp_analyzer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/resp_analyzer.sv
// MISR-based output response analyzer for the BIST chain: compacts PATTERNS CUT words, then
// compares the signature against GOLDEN. Optional stall timeout is enabled by RA_TIMEOUT_EN.
module resp_analyzer #(
  parameter int                 WIDTH    = 3,
  parameter int                 PATTERNS = 7,
  parameter logic [WIDTH-1:0]   TAPS     = 3'b110,
  parameter logic [WIDTH-1:0]   SEED     = 3'b000,
  parameter logic [WIDTH-1:0]   GOLDEN   = 3'b100,
  parameter int                 TIMEOUT  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        din_valid,
  input  logic [WIDTH-1:0]            din,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [WIDTH-1:0]            signature,
  output logic [$clog2(PATTERNS):0]   count,
  output logic                        timeout
);

  localparam int CW = $clog2(PATTERNS) + 1;
  localparam logic [CW-1:0] LAST = CW'(PATTERNS - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPACT = 2'd1;
  localparam logic [1:0] COMPARE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]       state;
  logic             fb;
  logic [WIDTH-1:0] nextsig;

  // MISR next value: tapped feedback into bit 0, shift upward, response word XORed in
  always_comb begin
    nextsig    = '0;
    fb         = ^(signature & TAPS);
    nextsig[0] = fb ^ din[0];
    for (int i = 1; i < WIDTH; i++) begin
      nextsig[i] = signature[i-1] ^ din[i];
    end
  end

`ifdef RA_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      signature <= SEED;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
`ifdef RA_TIMEOUT_EN
      stall     <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= COMPACT;
            signature <= SEED;
            count     <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
`ifdef RA_TIMEOUT_EN
            stall     <= '0;
            timeout   <= 1'b0;
`endif
          end
        end
        COMPACT: begin
`ifdef RA_TIMEOUT_EN
          if (stall == SW'(TIMEOUT)) begin
            state   <= DONE;
            done    <= 1'b1;
            pass    <= 1'b0;
            timeout <= 1'b1;
            busy    <= 1'b0;
          end else
`endif
          if (din_valid) begin
            signature <= nextsig;
            count     <= count + 1'b1;
`ifdef RA_TIMEOUT_EN
            stall     <= '0;
`endif
            // The word that brings count to PATTERNS closes the run
            if (count == LAST) begin
              state <= COMPARE;
            end
          end
`ifdef RA_TIMEOUT_EN
          else begin
            stall <= stall + 1'b1;
          end
`endif
        end
        COMPARE: begin
          pass  <= (signature == GOLDEN);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_resp_analyzer.sv
// Self-checking bench for resp_analyzer: spec-level model compared every cycle, plus
// hand-computed literal expectations for the directed runs.
module tb_resp_analyzer;

  logic       clk = 1'b0;
  logic       reset, start, din_valid;
  logic [2:0] din;
  logic       busy, done, pass, timeout;
  logic [2:0] signature;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;
  bit compareEn = 1'b0;

`ifdef RA_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic [2:0] words[7];
  logic [2:0] passWords[7] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
  logic [2:0] failWords[7] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
  logic [2:0] expSeq[7]    = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};

  resp_analyzer dut (
    .clk(clk), .reset(reset), .start(start), .din_valid(din_valid), .din(din),
    .busy(busy), .done(done), .pass(pass), .signature(signature), .count(count),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference: phase 0 idle, 1 collecting, 2 judging, 3 finished
  int         mPhase, mCount, mStall;
  logic [2:0] mSig;
  bit         mPass, mDone, mTimeout;

  function automatic logic [2:0] misr(input logic [2:0] s, input logic [2:0] d);
    logic fb;
    fb = s[1] ^ s[2];
    return {s[1:0], fb} ^ d;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mPhase <= 0; mSig <= 3'b000; mCount <= 0; mStall <= 0;
      mPass <= 0; mDone <= 0; mTimeout <= 0;
    end else if (mPhase == 0 || mPhase == 3) begin
      if (start) begin
        mPhase <= 1; mSig <= 3'b000; mCount <= 0; mStall <= 0;
        mPass <= 0; mDone <= 0; mTimeout <= 0;
      end
    end else if (mPhase == 1) begin
      if (TO_EN && mStall == 16) begin
        mPhase <= 3; mDone <= 1; mPass <= 0; mTimeout <= 1;
      end else if (din_valid) begin
        mSig   <= misr(mSig, din);
        mCount <= mCount + 1;
        mStall <= 0;
        if (mCount + 1 == 7) mPhase <= 2;
      end else begin
        mStall <= mStall + 1;
      end
    end else begin
      mPhase <= 3; mDone <= 1; mPass <= (mSig == 3'b100);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (compareEn && !reset) begin
      checkOutput("model_busy", busy, (mPhase == 1 || mPhase == 2));
      checkOutput("model_done", done, mDone);
      checkOutput("model_pass", pass, mPass);
      checkOutput("model_signature", signature, mSig);
      checkOutput("model_count", count, mCount);
      checkOutput("model_timeout", timeout, mTimeout);
    end
  end

  task automatic applyStimulus(input logic s, input logic v, input logic [2:0] d);
    start = s; din_valid = v; din = d;
    @(posedge clk);
    #1;
    start = 1'b0; din_valid = 1'b0;
  endtask

  task automatic waitDone(input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      applyStimulus(1'b0, 1'b0, 3'b000);
      n++;
    end
    if (!done) checkOutput("wait_done_bound", done, 1);
  endtask

  task automatic runWords(input int gap);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, words[i]);
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 3'b101);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; din_valid = 1'b0; din = 3'b000;
    @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_sig", signature, 0);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_timeout", timeout, 0);
    reset = 1'b0;
    compareEn = 1'b1;

    $display("[TB] mid-run reset");
    applyStimulus(1'b1, 1'b0, 3'b000);
    applyStimulus(1'b0, 1'b1, 3'b001);
    applyStimulus(1'b0, 1'b1, 3'b000);
    applyStimulus(1'b0, 1'b1, 3'b000);
    checkOutput("pre_reset_count", count, 3);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_sig", signature, 0);
    checkOutput("midreset_count", count, 0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 3'b111);
    checkOutput("idle_ignores_din", signature, 0);
    checkOutput("idle_not_busy", busy, 0);

    $display("[TB] passing run, start with din_valid on same edge");
    applyStimulus(1'b1, 1'b1, 3'b111);
    checkOutput("start_no_compact", signature, 0);
    checkOutput("start_busy", busy, 1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, passWords[i]);
      checkOutput("pass_seq", signature, expSeq[i]);
    end
    checkOutput("compare_done_low", done, 0);
    applyStimulus(1'b0, 1'b1, 3'b111);
    checkOutput("pass_done", done, 1);
    checkOutput("pass_pass", pass, 1);
    checkOutput("pass_count", count, 7);
    checkOutput("pass_sig", signature, 3'b100);
    applyStimulus(1'b0, 1'b1, 3'b111);
    checkOutput("done_hold", done, 1);

    $display("[TB] restart and failing run");
    applyStimulus(1'b1, 1'b0, 3'b000);
    checkOutput("restart_done", done, 0);
    checkOutput("restart_sig", signature, 0);
    words = failWords;
    runWords(0);
    waitDone(5);
    checkOutput("fail_sig", signature, 3'b010);
    checkOutput("fail_pass", pass, 0);

    $display("[TB] passing run with gaps");
    applyStimulus(1'b1, 1'b0, 3'b000);
    words = passWords;
    runWords(2);
    waitDone(5);
    checkOutput("gap_sig", signature, 3'b100);
    checkOutput("gap_pass", pass, 1);

    $display("[TB] start pulses while busy, din_valid in compare");
    applyStimulus(1'b1, 1'b0, 3'b000);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, passWords[i]);
    applyStimulus(1'b1, 1'b1, 3'b111);
    checkOutput("busy_start_done", done, 1);
    checkOutput("busy_start_sig", signature, 3'b100);
    checkOutput("busy_start_pass", pass, 1);

    $display("[TB] stall after two words");
    applyStimulus(1'b1, 1'b0, 3'b000);
    applyStimulus(1'b0, 1'b1, 3'b001);
    applyStimulus(1'b0, 1'b1, 3'b000);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 3'b000);
    checkOutput("stall16_done", done, 0);
    applyStimulus(1'b0, 1'b0, 3'b000);
    checkOutput("stall_count", count, 2);
    checkOutput("stall_sig", signature, 3'b010);
    checkOutput("stall_timeout", timeout, TO_EN);
    checkOutput("stall_done", done, TO_EN);
    checkOutput("stall_busy", busy, !TO_EN);
    checkOutput("stall_pass", pass, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 3'b000);
    checkOutput("stall_late_busy", busy, !TO_EN);

    compareEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
